// File: rtl/uart_mmio_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_mmio_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Register select values (Address[3:2])
  localparam logic [1:0] TXDATA_OFS  = 2'd0;
  localparam logic [1:0] STATUS_OFS  = 2'd1;
  localparam logic [1:0] BAUDDIV_OFS = 2'd2;

  // STATUS bit positions
  localparam int BUSY_BIT = 0;
  localparam int DONE_BIT = 1;
  localparam int OVR_BIT  = 2;

endpackage

// File: rtl/uart_tx_mmio_baud_counter.sv
// Bit-period timer: counts 0..div-1 and flags the last cycle of each period.
module baud_counter #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 bitTick
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] last;

  // div is never 0 (the register forces 1), so div-1 cannot underflow
  // and the counter never wraps past it.
  assign last    = div - DIV_WIDTH'(1);
  assign bitTick = (cnt == last);

  // Count up, reload at each bit boundary, hold at zero while cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cnt <= '0;
    else if (clear)   cnt <= '0;
    else if (bitTick) cnt <= '0;
    else              cnt <= cnt + DIV_WIDTH'(1);
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// MMIO UART transmitter: TXDATA/STATUS/BAUDDIV registers, 8N1 serialiser.
module uart_tx_mmio #(
  parameter int WORD_LENGTH = 32,
  parameter int BAUD_DIV    = 434,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enableUART,
  input  logic                   MemWrite,
  input  logic                   MemRead,
  input  logic [3:0]             Address,
  input  logic [WORD_LENGTH-1:0] WriteData,
  output logic [WORD_LENGTH-1:0] ReadData,
  output logic                   tx,
  output logic                   txBusy
);
  import uart_mmio_pkg::*;

  state_t               state, state_next;
  logic [2:0]           bit_idx, bit_idx_next, bit_idx_inc;
  logic                 tx_next;
  logic [7:0]           txdata;
  logic [DIV_WIDTH-1:0] baud_div;
  logic                 done, ovr;
  logic                 bit_tick;

  logic                 wr, rd;
  logic [1:0]           reg_sel;
  logic                 accept, tx_when_busy, frame_end, status_wr, baud_wr;
  logic                 baud_clear;
  logic                 unused_bits;

  assign wr      = enableUART & MemWrite;
  assign rd      = enableUART & MemRead;
  assign reg_sel = Address[3:2];

  // A TXDATA store only starts a frame from IDLE; the STOP-completion edge
  // still counts as busy, so a store there is an overrun.
  assign accept       = wr && (reg_sel == TXDATA_OFS) && (state == IDLE);
  assign tx_when_busy = wr && (reg_sel == TXDATA_OFS) && (state != IDLE);
  assign frame_end    = (state == STOP) && bit_tick;
  assign status_wr    = wr && (reg_sel == STATUS_OFS);
  assign baud_wr      = wr && (reg_sel == BAUDDIV_OFS) && (state == IDLE);
  assign bit_idx_inc  = bit_idx + 3'd1;
  assign txBusy       = (state != IDLE);
  assign baud_clear   = (state == IDLE);

  assign unused_bits = ^{Address[1:0], WriteData[WORD_LENGTH-1:DIV_WIDTH]};

  baud_counter #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (baud_clear),
    .div     (baud_div),
    .bitTick (bit_tick)
  );

  // Sequencer state, bit index and registered serial line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_idx <= 3'd0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      bit_idx <= bit_idx_next;
      tx      <= tx_next;
    end
  end

  // Next state and next line level; tx_next is what the line shows after the edge.
  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    tx_next      = 1'b1;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next   = START;
          bit_idx_next = 3'd0;
          tx_next      = 1'b0;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_tick) begin
          state_next   = DATA;
          bit_idx_next = 3'd0;
          tx_next      = txdata[0];
        end
      end
      DATA: begin
        tx_next = txdata[bit_idx];
        if (bit_tick) begin
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx_inc;
            tx_next      = txdata[bit_idx_inc];
          end
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (bit_tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Software-visible registers; set of done/overrun wins over W1C on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txdata   <= 8'h00;
      baud_div <= DIV_WIDTH'(BAUD_DIV);
      done     <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      if (accept) txdata <= WriteData[7:0];
      if (baud_wr)
        baud_div <= (WriteData[DIV_WIDTH-1:0] == '0) ? DIV_WIDTH'(1)
                                                     : WriteData[DIV_WIDTH-1:0];
      done <= frame_end    | (done & ~(status_wr & WriteData[DONE_BIT]));
      ovr  <= tx_when_busy | (ovr  & ~(status_wr & WriteData[OVR_BIT]));
    end
  end

  // Side-effect-free read mux; zero when not selected for a load.
  always_comb begin
    ReadData = '0;
    if (rd) begin
      case (reg_sel)
        TXDATA_OFS:  ReadData[7:0] = txdata;
        STATUS_OFS: begin
          ReadData[BUSY_BIT] = txBusy;
          ReadData[DONE_BIT] = done;
          ReadData[OVR_BIT]  = ovr;
        end
        BAUDDIV_OFS: ReadData[DIV_WIDTH-1:0] = baud_div;
        default:     ReadData = '0;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter peripheral for the multicycle MIPS data bus.
- Acts as the responder selected by the memory map's `enableUART` strobe.
- CPU stores a byte into TXDATA; the block serialises it as 8N1 on `tx`.
- Status and baud divisor are readable over the same bus.

Parameters:
- WORD_LENGTH, 32, bus data width (WriteData/ReadData).
- BAUD_DIV, 434, reset value of baud divisor in clk cycles per bit (50 MHz / 115200).
- DIV_WIDTH, 16, width of baud divisor register and counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enableUART  input  1  peripheral select from memory map decoder.
- MemWrite  input  1  bus write strobe; qualified by enableUART.
- MemRead  input  1  bus read strobe; qualified by enableUART.
- Address  input  4  byte offset within peripheral; bits [3:2] select register.
- WriteData  input  WORD_LENGTH  store data.
- ReadData  output  WORD_LENGTH  load data (combinational).
- tx  output  1  serial line, idle high.
- txBusy  output  1  frame in progress.

Behaviour:
- Reset (async): tx=1, txBusy=0, state=IDLE, TXDATA=0, BAUDDIV=BAUD_DIV, STATUS sticky bits=0, counters=0.
- Register map by Address[3:2]:
  - 0 TXDATA (W: byte WriteData[7:0]; R: last accepted byte).
  - 1 STATUS (R: bit0 busy, bit1 done, bit2 overrun, others 0; W: write-1-to-clear bits 1,2).
  - 2 BAUDDIV (R/W, low DIV_WIDTH bits).
  - 3 reserved (reads 0, writes ignored).
- wr = enableUART & MemWrite; rd = enableUART & MemRead.
- ReadData:
  - Combinational from the register map when rd=1, else all zeros.
  - No read side effects; reading STATUS does not clear it.
- TXDATA write while IDLE:
  - Byte latched at edge N.
  - State→START and txBusy=1 at edge N; tx=0 visible after edge N.
- TXDATA write while busy:
  - Byte discarded; overrun set.
  - Frame in progress unaffected.
- FSM:
  - IDLE→START→DATA→STOP→IDLE.
  - Each state bit lasts exactly BAUDDIV cycles, counted by the baud counter, which reloads at each bit boundary.
  - START drives tx=0.
  - DATA sends bits 0..7, LSB first, bit index 0→7.
  - STOP drives tx=1.
  - At end of STOP: state=IDLE, txBusy=0, done=1, all on the same edge.
- Frame length: exactly 10×BAUDDIV cycles from the accept edge to the txBusy fall edge.
- Back-to-back: a TXDATA write on the first cycle txBusy=0 starts a new frame with no extra idle gap beyond that cycle.
- BAUDDIV writes:
  - Accepted only in IDLE; ignored while busy (no overrun).
  - A written value of 0 is stored as 1.
- Simultaneous events:
  - STATUS W1C on the same edge that sets done/overrun: the set wins.
  - TXDATA write on the same edge the STOP bit completes: counted as busy, so overrun is set and the byte is dropped.
- Reset mid-frame: tx returns high immediately and asynchronously; frame abandoned; no done set.
- Counters are DIV_WIDTH bits and never wrap: the compare is to BAUDDIV-1.

Decomposition:
- Package uart_mmio_pkg:
  - FSM state enum (IDLE, START, DATA, STOP).
  - Register offsets (TXDATA_OFS=0, STATUS_OFS=1, BAUDDIV_OFS=2).
  - STATUS bit indices (BUSY_BIT=0, DONE_BIT=1, OVR_BIT=2).
- One sub-module, baud_counter:
  - Parameters: DIV_WIDTH.
  - Inputs: clk, reset, clear, div.
  - Output: bitTick, pulsed on the last cycle of each bit period.

Test Plan:
- Reset, then read STATUS/BAUDDIV → ReadData=0x0 and 434; tx=1, txBusy=0.
- BAUDDIV=4, write TXDATA=0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; txBusy high 40 cycles; STATUS then reads 0x2.
- BAUDDIV=4, write 0x3C, then write 0xFF at cycle 10 → frame still carries 0x3C; STATUS=0x6 after frame; write STATUS 0x6 → reads 0x0.
- Write BAUDDIV=0 → reads back 1; write 0x55 → each bit 1 cycle, frame 10 cycles.
- Assert reset at cycle 15 of a BAUDDIV=4 frame → tx=1 immediately, txBusy=0, done=0; next write 0x81 transmits a correct frame.
- enableUART=0 with MemWrite=1 to TXDATA → no frame starts; ReadData=0 when MemRead=1 and enableUART=0.
